ifetch_unit: RTL and testbench

Instruction-fetch stage of the single-cycle RISC-V core. It sits directly upstream of the instruction decoder/controller.
- Holds the PC and a synchronous-read instruction memory.
- Supplies inst/pc to decode and resolves next-PC from the decoder's Branch/Jump/BranchType outputs and register/immediate operands.
- Provides a write port so the program image can be loaded at run time.

---
 rtl/ifetch_unit.sv | 136 +++++++++++++
 tb/tb_ifetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, synchronous-read instruction memory and next-PC resolution.
// Optional branch trace counters are built in when IFETCH_BTRACE_EN is defined.
module ifetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               Branch,
  input  logic               Jump,
  input  logic               jalr,
  input  logic [2:0]         BranchType,
  input  logic [31:0]        rs1_data,
  input  logic [31:0]        rs2_data,
  input  logic [31:0]        imm,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  output logic [31:0]        inst,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               inst_valid,
  output logic               misalign_err
`ifdef IFETCH_BTRACE_EN
  ,
  output logic [31:0]        redirect_cnt,
  output logic [31:0]        last_target
`endif
);

  typedef enum logic [1:0] {FILL, RUN, HALT} state_t;

  state_t              state_reg, state_next;
  logic [31:0]         pc_reg, pc_next, inst_reg, seq_pc, target;
  logic                misalign_reg, misalign_next;
  logic                taken, redirect, accept_redirect, rd_en;
  logic [IMEM_AW-1:0]  raddr;
  logic [31:0]         mem [0:(1<<IMEM_AW)-1];

  always_comb begin
    taken = 1'b0;
    case (BranchType)
      3'b000:  taken = (rs1_data == rs2_data);
      3'b001:  taken = (rs1_data != rs2_data);
      3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  taken = (rs1_data <  rs2_data);
      3'b111:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  assign seq_pc   = pc_reg + 32'd4;
  assign target   = (Jump && jalr) ? ((rs1_data + imm) & ~32'h1) : (pc_reg + imm);
  assign redirect = Jump | (Branch & taken);

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    misalign_next   = misalign_reg;
    accept_redirect = 1'b0;
    case (state_reg)
      FILL: state_next = RUN;
      RUN: begin
        if (!stall) begin
          if (redirect) begin
            // A target with bit 1 set is never fetched; the stage parks until reset.
            if (target[1]) begin
              state_next    = HALT;
              misalign_next = 1'b1;
            end else begin
              pc_next         = target;
              accept_redirect = 1'b1;
            end
          end else begin
            pc_next = seq_pc;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= PC_RESET;
      state_reg    <= FILL;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      state_reg    <= state_next;
      misalign_reg <= misalign_next;
    end
  end

  // Read address follows next_pc so the registered read lines up with pc.
  assign raddr = pc_next[IMEM_AW+1:2];
  assign rd_en = !(state_reg == RUN && stall);

  always_ff @(posedge clk) begin
    if (imem_we)
      mem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      inst_reg <= 32'h0;
    else if (rd_en)
      inst_reg <= mem[raddr];
  end

`ifdef IFETCH_BTRACE_EN
  logic [31:0] redirect_cnt_reg, last_target_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_reg <= 32'h0;
      last_target_reg  <= 32'h0;
    end else if (accept_redirect) begin
      redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
      last_target_reg  <= pc_next;
    end
  end

  assign redirect_cnt = redirect_cnt_reg;
  assign last_target  = last_target_reg;
`endif

  assign inst         = inst_reg;
  assign pc           = pc_reg;
  assign pc_plus4     = seq_pc;
  assign inst_valid   = (state_reg == RUN) && !stall && !rst;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a behavioural fetch model checked every cycle plus directed literal checks.
module tb_ifetch_unit;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst, stall, Branch, Jump, jalr;
  logic [2:0]    BranchType;
  logic [31:0]   rs1_data, rs2_data, imm;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   inst, pc, pc_plus4;
  logic          inst_valid, misalign_err;
`ifdef IFETCH_BTRACE_EN
  logic [31:0]   redirect_cnt, last_target;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  ifetch_unit #(.PC_RESET(32'h0), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .Branch(Branch), .Jump(Jump), .jalr(jalr),
    .BranchType(BranchType), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .inst(inst), .pc(pc), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
    .misalign_err(misalign_err)
`ifdef IFETCH_BTRACE_EN
    , .redirect_cnt(redirect_cnt), .last_target(last_target)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%08h expected=%08h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: program memory image, fetch mode (0 fill, 1 run, 2 halted) and the architectural pc.
  logic [31:0] m_mem   [0:(1<<AW)-1];
  bit          m_known [0:(1<<AW)-1];
  logic [31:0] m_pc, m_inst, m_rcnt, m_last;
  int          m_mode;
  bit          m_err, m_inst_ok;
  logic [33:0] m_step;

  // Returns {is_redirect, misaligned, next pc} for one executed instruction.
  function automatic logic [33:0] model_next(input logic [31:0] p, input logic br, jp, jr,
                                              input logic [2:0] bt, input logic [31:0] a, b, im);
    bit tk;
    logic [31:0] t;
    tk = 0;
    if (bt == 3'd0) tk = (a == b);
    if (bt == 3'd1) tk = (a != b);
    if (bt == 3'd4) tk = ($signed(a) < $signed(b));
    if (bt == 3'd5) tk = !($signed(a) < $signed(b));
    if (bt == 3'd6) tk = (a < b);
    if (bt == 3'd7) tk = !(a < b);
    if (jp && jr)      t = (a + im) & 32'hFFFF_FFFE;
    else if (jp)       t = p + im;
    else if (br && tk) t = p + im;
    else return {1'b0, 1'b0, p + 32'd4};
    return {1'b1, t[1], t};
  endfunction

  assign m_step = model_next(m_pc, Branch, Jump, jalr, BranchType, rs1_data, rs2_data, imm);

  always @(posedge clk) begin
    if (imem_we) begin
      m_mem[imem_waddr]   <= imem_wdata;
      m_known[imem_waddr] <= 1'b1;
    end
    if (rst) begin
      m_pc <= 32'h0; m_mode <= 0; m_err <= 1'b0; m_inst_ok <= 1'b0;
      m_rcnt <= 32'h0; m_last <= 32'h0;
    end else if (m_mode == 0) begin
      m_mode    <= 1;
      m_inst    <= m_mem[m_pc[AW+1:2]];
      m_inst_ok <= m_known[m_pc[AW+1:2]];
    end else if (m_mode == 1 && !stall) begin
      if (m_step[32]) begin
        m_mode <= 2;
        m_err  <= 1'b1;
      end else begin
        m_pc      <= m_step[31:0];
        m_inst    <= m_mem[m_step[AW+1:2]];
        m_inst_ok <= m_known[m_step[AW+1:2]];
        if (m_step[33]) begin
          m_rcnt <= m_rcnt + 32'd1;
          m_last <= m_step[31:0];
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("m_valid", {31'h0, inst_valid}, {31'h0, (m_mode == 1) && !stall && !rst});
      chk("m_misalign", {31'h0, misalign_err}, {31'h0, m_err});
      if ((m_mode == 1) && !stall && !rst && m_inst_ok)
        chk("m_inst", inst, m_inst);
`ifdef IFETCH_BTRACE_EN
      chk("m_rcnt", redirect_cnt, m_rcnt);
      chk("m_last", last_target, m_last);
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_ctl(input logic br, jp, jr, input logic [2:0] bt,
                         input logic [31:0] a, b, im);
    Branch = br; Jump = jp; jalr = jr; BranchType = bt;
    rs1_data = a; rs2_data = b; imm = im;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    set_ctl(0, 0, 0, 3'd0, 0, 0, 0);
    tick;
    cmp_en = 1'b1;
    // Program load while reset is held.
    for (int i = 0; i <= 32'h50; i++) begin
      imem_we    = 1'b1;
      imem_waddr = AW'(i);
      imem_wdata = (i == 0) ? 32'h0050_0093 : (i == 1) ? 32'h0010_0113 : (32'hC0DE_0000 | 32'(i));
      tick;
    end
    imem_waddr = AW'(32'h410); imem_wdata = 32'h1040_1040;
    tick;
    imem_we = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_err", {31'h0, misalign_err}, 32'h0);
    chk("rst_inst", inst, 32'h0);

    rst = 1'b0; #1;
    chk("fill_valid", {31'h0, inst_valid}, 32'h0);
    tick; chk("first_pc", pc, 32'h0); chk("first_inst", inst, 32'h0050_0093);
    chk("first_valid", {31'h0, inst_valid}, 32'h1);
    tick; chk("second_pc", pc, 32'h4); chk("second_inst", inst, 32'h0010_0113);
    chk("second_pc4", pc_plus4, 32'h8);
    tick; chk("seq_pc", pc, 32'h8);

    stall = 1'b1; set_ctl(0, 1, 0, 3'd0, 0, 0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_pc", pc, 32'h8);
      chk("stall_valid", {31'h0, inst_valid}, 32'h0);
      chk("stall_inst", inst, 32'hC0DE_0002);
    end
    stall = 1'b0;
    tick; chk("jump_once", pc, 32'h10);

    set_ctl(1, 0, 0, 3'b000, 5, 5, 32'hFFFF_FFF8);
    tick; chk("beq_taken", pc, 32'h8);
    set_ctl(0, 0, 0, 3'd0, 0, 0, 0);
    tick; tick; chk("back_to_10", pc, 32'h10);
    set_ctl(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 1, 32'h20);
    tick; chk("blt_signed", pc, 32'h30);
    set_ctl(0, 1, 0, 3'd0, 0, 0, 32'hFFFF_FFE0);
    tick; chk("jal_back", pc, 32'h10);
    set_ctl(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 1, 32'h20);
    tick; chk("bltu_not", pc, 32'h14);
    set_ctl(0, 1, 1, 3'd0, 32'h101, 0, 0);
    tick; chk("jalr_lsb", pc, 32'h100);
    set_ctl(0, 1, 0, 3'd0, 0, 0, 32'hFFFF_FF40);
    tick; chk("jal_to_40", pc, 32'h40);
    set_ctl(0, 1, 0, 3'd0, 0, 0, 32'h1000);
    tick; chk("jal_far", pc, 32'h1040); chk("jal_far_inst", inst, 32'h1040_1040);
    set_ctl(0, 1, 0, 3'd0, 0, 0, 32'hFFFF_EFDC);
    tick; chk("jal_1c", pc, 32'h1C); chk("jal_1c_inst", inst, 32'hC0DE_0007);

    // Overwrite word 8 on the same edge it is fetched.
    set_ctl(0, 0, 0, 3'd0, 0, 0, 0);
    imem_we = 1'b1; imem_waddr = AW'(8); imem_wdata = 32'hDEAD_BEEF;
    tick; imem_we = 1'b0;
    chk("collide_pc", pc, 32'h20); chk("collide_old", inst, 32'hC0DE_0008);
    set_ctl(0, 1, 0, 3'd0, 0, 0, 0);
    tick; chk("refetch_pc", pc, 32'h20); chk("refetch_new", inst, 32'hDEAD_BEEF);

    set_ctl(1, 0, 0, 3'b000, 3, 3, 32'h6);
    tick;
    chk("mis_err", {31'h0, misalign_err}, 32'h1);
    chk("mis_valid", {31'h0, inst_valid}, 32'h0);
    chk("mis_pc", pc, 32'h20);
    set_ctl(0, 1, 0, 3'd0, 0, 0, 32'h40);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("halt_pc", pc, 32'h20);
      chk("halt_err", {31'h0, misalign_err}, 32'h1);
    end
    rst = 1'b1;
    tick; chk("rerst_err", {31'h0, misalign_err}, 32'h0); chk("rerst_pc", pc, 32'h0);
    rst = 1'b0; set_ctl(1, 0, 0, 3'b010, 7, 7, 32'h40);
    tick; chk("restart_pc", pc, 32'h0); chk("restart_inst", inst, 32'h0050_0093);
    tick; chk("bt010_never", pc, 32'h4);
    set_ctl(1, 0, 0, 3'b001, 1, 2, 32'h10);
    tick; chk("bne_taken", pc, 32'h14);

    set_ctl(0, 1, 1, 3'd0, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF);
    tick; chk("top_pc", pc, 32'hFFFF_FFFC); chk("top_pc4", pc_plus4, 32'h0);
    set_ctl(0, 0, 0, 3'd0, 0, 0, 0);
    tick; chk("wrap_pc", pc, 32'h0); chk("wrap_inst", inst, 32'h0050_0093);

    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
